// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Serial-to-parallel UART receiver, companion to the 16x-oversampled
// transmitter. A frame is one start bit (0), DBIT data bits LSB first and a
// stop bit (1) lasting SB_TICK s_ticks. Received words are handed over
// through a one-entry valid/ready holding register. Bad stop bits and words
// arriving while the holding register is full are reported as 1-clk pulses.
//
// Ports
//   clk          system clock, everything registered on the rising edge
//   reset        synchronous active-high reset
//   s_tick       1-clk enable pulse at 16x the baud rate
//   rx           asynchronous serial line, idles high
//   rx_dout      received word, valid while rx_valid = 1
//   rx_valid     holding register full
//   rx_ready     consumer takes rx_dout in any cycle with rx_valid & rx_ready
//   rx_done_tick 1-clk pulse when a good frame lands in the holding register
//   frame_err    1-clk pulse when the stop bit is sampled low
//   overrun_err  1-clk pulse when a good frame is dropped because the
//                holding register is still full
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            overrun_err
);

    // The tick counter must reach SB_TICK-1 in the stop state, so it grows
    // beyond 4 bits for 1.5 or 2 stop bits.
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID_START = SW'(7);
    localparam logic [SW-1:0] S_MID_DATA  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    // Three state bits leave spare encodings; those fall back to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t          state_q;
    logic            rxMeta_q;
    logic            rxSync_q;
    logic [SW-1:0]   s_q;
    logic [NW-1:0]   n_q;
    logic [DBIT-1:0] b_q;
    logic [DBIT-1:0] dout_q;
    logic            valid_q;
    logic            doneTick_q;
    logic            frameErr_q;
    logic            overrunErr_q;

    logic [DBIT-1:0] shift_d;
    logic            canDeliver_d;

    // Next shift-register value (LSB arrives first, so shift right) and
    // whether the holding register can accept a word this cycle, either
    // because it is empty or because it is being emptied right now.
    always_comb begin
        shift_d      = {rxSync_q, b_q[DBIT-1:1]};
        canDeliver_d = !valid_q || rx_ready;
    end

    // Receiver FSM with its synchronizer, counters, holding register and
    // pulse outputs. A deliver in STOP overrides the consume-clear of
    // valid_q because it is the later non-blocking assignment.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rxMeta_q     <= 1'b1;
            rxSync_q     <= 1'b1;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            doneTick_q   <= 1'b0;
            frameErr_q   <= 1'b0;
            overrunErr_q <= 1'b0;
        end else begin
            rxMeta_q     <= rx;
            rxSync_q     <= rxMeta_q;
            doneTick_q   <= 1'b0;
            frameErr_q   <= 1'b0;
            overrunErr_q <= 1'b0;

            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rxSync_q) begin
                        s_q     <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == S_MID_START) begin
                            if (!rxSync_q) begin
                                s_q     <= '0;
                                n_q     <= '0;
                                state_q <= DATA;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == S_MID_DATA) begin
                            b_q <= shift_d;
                            s_q <= '0;
                            if (n_q == N_LAST) begin
                                state_q <= STOP;
                            end else begin
                                n_q <= n_q + NW'(1);
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_q == S_STOP_LAST) begin
                            s_q <= '0;
                            if (rxSync_q) begin
                                state_q <= IDLE;
                                if (canDeliver_d) begin
                                    dout_q     <= b_q;
                                    valid_q    <= 1'b1;
                                    doneTick_q <= 1'b1;
                                end else begin
                                    overrunErr_q <= 1'b1;
                                end
                            end else begin
                                frameErr_q <= 1'b1;
                                state_q    <= BRK;
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                // A held-low line must return high before a new start bit
                // is considered, so a break reports only one framing error.
                BRK: begin
                    if (rxSync_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_dout      = dout_q;
    assign rx_valid     = valid_q;
    assign rx_done_tick = doneTick_q;
    assign frame_err    = frameErr_q;
    assign overrun_err  = overrunErr_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Drives directed UART frames into two receivers: the default configuration
// (DBIT=8, SB_TICK=16) and a DBIT=7 / SB_TICK=32 variant. Every expected
// event (good word, framing error, overrun) is queued with its data and the
// clk cycle it must appear in; a monitor pops the queue whenever a receiver
// raises a pulse output. s_tick is one clk in every four, so a bit lasts
// 64 clk. With the 2-FF synchronizer, each event of a frame lands on tick
// 152 counted from the start-bit edge, i.e. 608 clk after the line falls.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int KDONE    = 1;
    localparam int KFRAME   = 2;
    localparam int KOVR     = 3;
    localparam int EVT_DLY  = 608;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sTick;
    logic       rx0, rx1;
    logic       ready0, ready1;
    logic [7:0] dout0;
    logic [6:0] dout1;
    logic       valid0, valid1;
    logic       done0, done1;
    logic       ferr0, ferr1;
    logic       ovr0, ovr1;

    longint     cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (sTick),
        .rx           (rx0),
        .rx_dout      (dout0),
        .rx_valid     (valid0),
        .rx_ready     (ready0),
        .rx_done_tick (done0),
        .frame_err    (ferr0),
        .overrun_err  (ovr0)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (sTick),
        .rx           (rx1),
        .rx_dout      (dout1),
        .rx_valid     (valid1),
        .rx_ready     (ready1),
        .rx_done_tick (done1),
        .frame_err    (ferr1),
        .overrun_err  (ovr1)
    );

    // Free-running clock and a cycle counter used to time-stamp events.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic popCheck(input int line, input int kind, input logic [7:0] dout);
        exp_t e;
        string tag;
        tag = (line == 0) ? "dut0" : "dut1";
        if ((line == 0 && q0.size() == 0) || (line == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s unexpected event: got kind %0d, expected none at cycle %0d",
                     tag, kind, cyc);
        end else begin
            if (line == 0) e = q0.pop_front();
            else           e = q1.pop_front();
            checkOutput({tag, " event kind"}, kind, e.kind);
            if (kind == e.kind) begin
                checkOutput({tag, " event data"}, dout, e.data);
                checkOutput({tag, " event cycle"}, cyc, e.cyc);
            end
        end
    endtask

    // Monitor: every pulse output, every cycle, consumes one queued event.
    always @(negedge clk) begin
        if (done0) popCheck(0, KDONE, dout0);
        if (ferr0) popCheck(0, KFRAME, dout0);
        if (ovr0)  popCheck(0, KOVR, dout0);
        if (done1) popCheck(1, KDONE, {1'b0, dout1});
        if (ferr1) popCheck(1, KFRAME, {1'b0, dout1});
        if (ovr1)  popCheck(1, KOVR, {1'b0, dout1});
    end

    task automatic setLine(input int line, input logic lvl);
        if (line == 0) rx0 = lvl;
        else           rx1 = lvl;
    endtask

    // One s_tick period: three quiet clk, then a 1-clk tick. rx_ready can be
    // raised in exactly the tick cycle.
    task automatic oneTick(input logic readyHere);
        repeat (3) @(negedge clk);
        sTick = 1'b1;
        if (readyHere) ready0 = 1'b1;
        @(negedge clk);
        sTick  = 1'b0;
        ready0 = 1'b0;
    endtask

    task automatic holdLine(input int line, input logic lvl, input int n);
        setLine(line, lvl);
        repeat (n) oneTick(1'b0);
    endtask

    // Sends one frame and queues the event it should cause. readyTick is the
    // frame-relative tick number at which rx_ready pulses (0 = never).
    task automatic applyStimulus(input int line, input logic [7:0] data, input int nData,
                                 input logic stopBit, input int stopTicks, input int kind,
                                 input logic [7:0] expData, input int readyTick);
        exp_t e;
        int   t;
        e.kind = kind;
        e.data = expData;
        e.cyc  = cyc + EVT_DLY;
        if (kind != 0) begin
            if (line == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
        t = 0;
        setLine(line, 1'b0);
        repeat (16) begin t++; oneTick(t == readyTick); end
        for (int i = 0; i < nData; i++) begin
            setLine(line, data[i]);
            repeat (16) begin t++; oneTick(t == readyTick); end
        end
        setLine(line, stopBit);
        repeat (stopTicks) begin t++; oneTick(t == readyTick); end
    endtask

    task automatic consume0;
        @(negedge clk);
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        checkOutput("valid cleared after consume", valid0, 0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " dout0"}, dout0, 0);
        checkOutput({name, " valid0"}, valid0, 0);
        checkOutput({name, " pulses0"}, {done0, ferr0, ovr0}, 0);
        checkOutput({name, " dout1"}, dout1, 0);
        checkOutput({name, " valid1"}, valid1, 0);
    endtask

    initial begin
        logic [7:0] abortPat;
        reset  = 1'b1;
        sTick  = 1'b0;
        rx0    = 1'b1;
        rx1    = 1'b1;
        ready0 = 1'b0;
        ready1 = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset state");
        reset = 1'b0;
        holdLine(0, 1'b1, 4);

        // Single word, nobody consuming: it must stay presented.
        applyStimulus(0, 8'hA5, 8, 1'b1, 16, KDONE, 8'hA5, 0);
        holdLine(0, 1'b1, 8);
        checkOutput("A5 dout", dout0, 8'hA5);
        checkOutput("A5 valid", valid0, 1);

        // Short low glitch: no event, holding register untouched.
        holdLine(0, 1'b0, 4);
        holdLine(0, 1'b1, 20);
        checkOutput("glitch valid kept", valid0, 1);
        checkOutput("glitch dout kept", dout0, 8'hA5);
        consume0();
        checkOutput("dout held after consume", dout0, 8'hA5);

        // Bad stop bit followed by a break, then a clean frame.
        applyStimulus(0, 8'h3C, 8, 1'b0, 16, KFRAME, 8'hA5, 0);
        holdLine(0, 1'b0, 40);
        checkOutput("bad frame valid", valid0, 0);
        holdLine(0, 1'b1, 16);
        applyStimulus(0, 8'h81, 8, 1'b1, 16, KDONE, 8'h81, 0);
        holdLine(0, 1'b1, 4);
        consume0();

        // Back-to-back with the register left full: second word overruns.
        applyStimulus(0, 8'h11, 8, 1'b1, 16, KDONE, 8'h11, 0);
        applyStimulus(0, 8'h22, 8, 1'b1, 16, KOVR, 8'h11, 0);
        holdLine(0, 1'b1, 4);
        checkOutput("overrun dout kept", dout0, 8'h11);
        checkOutput("overrun valid", valid0, 1);
        consume0();

        // Same pair, consuming in the very cycle the second word lands.
        applyStimulus(0, 8'h11, 8, 1'b1, 16, KDONE, 8'h11, 0);
        applyStimulus(0, 8'h22, 8, 1'b1, 16, KDONE, 8'h22, 152);
        holdLine(0, 1'b1, 4);
        checkOutput("fill-consume dout", dout0, 8'h22);
        checkOutput("fill-consume valid", valid0, 1);

        // Reset in the middle of data bit 4 with a word still held.
        abortPat = 8'h5A;
        holdLine(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) holdLine(0, abortPat[i], 16);
        holdLine(0, abortPat[4], 8);
        reset = 1'b1;
        rx0   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkAllZero("mid-frame reset");
        end
        reset = 1'b0;
        holdLine(0, 1'b1, 20);
        applyStimulus(0, 8'h7E, 8, 1'b1, 16, KDONE, 8'h7E, 0);
        holdLine(0, 1'b1, 4);
        checkOutput("7E dout", dout0, 8'h7E);

        // Seven data bits and two stop bits on the second receiver.
        applyStimulus(1, 8'h55, 7, 1'b1, 32, KDONE, 8'h55, 0);
        holdLine(1, 1'b1, 8);
        checkOutput("dbit7 dout", dout1, 7'h55);
        checkOutput("dbit7 valid", valid1, 1);

        holdLine(0, 1'b1, 8);
        checkOutput("dut0 events outstanding", q0.size(), 0);
        checkOutput("dut1 events outstanding", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
